hiscore_ram_arbiter: RTL and testbench

- Shares the game's work RAM port between the CPU and the hiscore save/restore engine.
- Halts the CPU at a safe point before handing the RAM to hiscore. The safe point is a vblank rising edge, or a timeout if no vblank arrives.
- Owns the whole pause policy: user pause toggle, OSD pause and the dim-video timer. It replaces the ad-hoc pause logic in the emu top level.
- Sits between hps_io/hiscore and the burger_time core, on clk_sys.

---
 rtl/hiscore_ram_arbiter_if.sv | 39 +++
 rtl/hiscore_ram_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_hiscore_ram_arbiter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/hiscore_ram_arbiter_if.sv
// Work-RAM bus bundle shared by the CPU, the hiscore engine and the RAM itself.
// The arbiter sits on the slave side; the surrounding system drives the master side.
interface hiscore_ram_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
);
    logic              hs_req;
    logic              hs_gnt;
    logic [ADDR_W-1:0] hs_addr;
    logic [DATA_W-1:0] hs_din;
    logic              hs_we;
    logic [DATA_W-1:0] hs_dout;

    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_din;
    logic              cpu_we;
    logic [DATA_W-1:0] cpu_dout;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic              ram_we;
    logic [DATA_W-1:0] ram_dout;

    modport slave (
        input  hs_req, hs_addr, hs_din, hs_we,
        input  cpu_addr, cpu_din, cpu_we,
        input  ram_dout,
        output hs_gnt, hs_dout, cpu_dout,
        output ram_addr, ram_din, ram_we
    );

    modport master (
        output hs_req, hs_addr, hs_din, hs_we,
        output cpu_addr, cpu_din, cpu_we,
        output ram_dout,
        input  hs_gnt, hs_dout, cpu_dout,
        input  ram_addr, ram_din, ram_we
    );
endinterface

// File: rtl/hiscore_ram_arbiter.sv
// Hands the work RAM to the hiscore engine only after the CPU is halted at a
// vblank edge (or timeout), and owns the whole user/OSD pause and dim policy.
module hiscore_ram_arbiter #(
    parameter int ADDR_W      = 11,
    parameter int DATA_W      = 8,
    parameter int SETTLE      = 2,
    parameter int VBL_TIMEOUT = 65536,
    parameter int DIM_CYCLES  = 240000000
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  vblank,
    input  logic                  pause_btn,
    input  logic                  osd_pause,
    hiscore_ram_arbiter_if.slave  bus,
    output logic                  cpu_pause,
    output logic                  dim_video
);

    localparam int TO_W = (VBL_TIMEOUT > 1) ? $clog2(VBL_TIMEOUT) : 1;
    // Release side holds for SETTLE cycles after the bus switch, so it needs to reach SETTLE.
    localparam int ST_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    localparam logic [TO_W-1:0] TO_LAST     = TO_W'(VBL_TIMEOUT - 1);
    localparam logic [ST_W-1:0] ST_IN_LAST  = ST_W'(SETTLE - 1);
    localparam logic [ST_W-1:0] ST_OUT_LAST = ST_W'(SETTLE);
    localparam logic [31:0]     DIM_MAX     = 32'(DIM_CYCLES);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_VBL   = 3'd1,
        SETTLE_IN  = 3'd2,
        GRANT      = 3'd3,
        SETTLE_OUT = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic              hs_gnt_q, hs_gnt_d;
    logic              hs_halt_q, hs_halt_d;
    logic [ST_W-1:0]   st_cnt_q, st_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              vbl_q;
    logic              btn_q;
    logic              toggle_q, toggle_d;
    logic [31:0]       dim_cnt_q, dim_cnt_d;
    logic              dim_q, dim_d;
    logic              vbl_rise_s;

    logic [ADDR_W-1:0] ram_addr_s;
    logic [DATA_W-1:0] ram_din_s;
    logic              ram_we_s;

    assign vbl_rise_s = vblank & ~vbl_q;

    // Ownership FSM: halt, wait for a safe point, settle, grant, settle back.
    always_comb begin
        state_d   = state_q;
        hs_gnt_d  = hs_gnt_q;
        hs_halt_d = hs_halt_q;
        st_cnt_d  = st_cnt_q;
        to_cnt_d  = to_cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.hs_req) begin
                    state_d   = WAIT_VBL;
                    hs_halt_d = 1'b1;
                    to_cnt_d  = '0;
                end else begin
                    hs_halt_d = 1'b0;
                end
            end
            WAIT_VBL: begin
                if (!bus.hs_req) begin
                    state_d  = SETTLE_OUT;
                    st_cnt_d = '0;
                    to_cnt_d = '0;
                end else if (vbl_rise_s || (to_cnt_q == TO_LAST)) begin
                    state_d  = SETTLE_IN;
                    st_cnt_d = '0;
                    to_cnt_d = '0;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            SETTLE_IN: begin
                if (st_cnt_q == ST_IN_LAST) begin
                    state_d  = GRANT;
                    hs_gnt_d = 1'b1;
                    st_cnt_d = '0;
                end else begin
                    st_cnt_d = st_cnt_q + ST_W'(1);
                end
            end
            GRANT: begin
                if (!bus.hs_req) begin
                    state_d  = SETTLE_OUT;
                    hs_gnt_d = 1'b0;
                    st_cnt_d = '0;
                end else begin
                    hs_gnt_d = 1'b1;
                end
            end
            SETTLE_OUT: begin
                if (st_cnt_q == ST_OUT_LAST) begin
                    state_d   = IDLE;
                    hs_halt_d = 1'b0;
                    st_cnt_d  = '0;
                end else begin
                    st_cnt_d = st_cnt_q + ST_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                hs_gnt_d  = 1'b0;
                hs_halt_d = 1'b0;
                st_cnt_d  = '0;
                to_cnt_d  = '0;
            end
        endcase
    end

    // User pause toggle and the dim timer that only the user pause advances.
    always_comb begin
        if (pause_btn && !btn_q) begin
            toggle_d = ~toggle_q;
        end else begin
            toggle_d = toggle_q;
        end
        if (!toggle_q) begin
            dim_cnt_d = 32'd0;
        end else if (dim_cnt_q == DIM_MAX) begin
            dim_cnt_d = dim_cnt_q;
        end else begin
            dim_cnt_d = dim_cnt_q + 32'd1;
        end
        dim_d = (dim_cnt_d == DIM_MAX);
    end

    // State and policy registers.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            hs_gnt_q  <= 1'b0;
            hs_halt_q <= 1'b0;
            st_cnt_q  <= '0;
            to_cnt_q  <= '0;
            vbl_q     <= 1'b0;
            btn_q     <= 1'b0;
            toggle_q  <= 1'b0;
            dim_cnt_q <= 32'd0;
            dim_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hs_gnt_q  <= hs_gnt_d;
            hs_halt_q <= hs_halt_d;
            st_cnt_q  <= st_cnt_d;
            to_cnt_q  <= to_cnt_d;
            vbl_q     <= vblank;
            btn_q     <= pause_btn;
            toggle_q  <= toggle_d;
            dim_cnt_q <= dim_cnt_d;
            dim_q     <= dim_d;
        end
    end

    // Bus mux steered by the registered grant; the non-owner's write is dropped.
    always_comb begin
        if (hs_gnt_q) begin
            ram_addr_s = bus.hs_addr;
            ram_din_s  = bus.hs_din;
            ram_we_s   = bus.hs_we;
        end else begin
            ram_addr_s = bus.cpu_addr;
            ram_din_s  = bus.cpu_din;
            ram_we_s   = bus.cpu_we;
        end
    end

    assign bus.ram_addr = ram_addr_s;
    assign bus.ram_din  = ram_din_s;
    assign bus.ram_we   = ram_we_s;
    assign bus.hs_gnt   = hs_gnt_q;
    assign bus.cpu_dout = bus.ram_dout;
    assign bus.hs_dout  = bus.ram_dout;

    // osd_pause goes straight through so the core stops the cycle the OSD opens.
    assign cpu_pause = hs_halt_q | toggle_q | osd_pause;
    assign dim_video = dim_q;

endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// Directed bench for hiscore_ram_arbiter with short timeout/dim parameters.
module tb_hiscore_ram_arbiter;

    logic clk_sys = 1'b0;
    logic reset;
    logic vblank;
    logic pause_btn;
    logic osd_pause;
    logic cpu_pause;
    logic dim_video;

    int n_cmp = 0;
    int n_err = 0;

    hiscore_ram_arbiter_if #(.ADDR_W(11), .DATA_W(8)) bus ();

    hiscore_ram_arbiter #(
        .ADDR_W      (11),
        .DATA_W      (8),
        .SETTLE      (2),
        .VBL_TIMEOUT (16),
        .DIM_CYCLES  (100)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .vblank    (vblank),
        .pause_btn (pause_btn),
        .osd_pause (osd_pause),
        .bus       (bus),
        .cpu_pause (cpu_pause),
        .dim_video (dim_video)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        vblank       = 1'b0;
        pause_btn    = 1'b0;
        osd_pause    = 1'b0;
        bus.hs_req   = 1'b0;
        bus.hs_addr  = 11'h155;
        bus.hs_din   = 8'hA5;
        bus.hs_we    = 1'b0;
        bus.cpu_addr = 11'h2AA;
        bus.cpu_din  = 8'h3C;
        bus.cpu_we   = 1'b1;
        bus.ram_dout = 8'h5A;

        // Reset state
        #12;
        check_eq("rst_gnt",   32'(bus.hs_gnt),   32'h0);
        check_eq("rst_pause", 32'(cpu_pause),    32'h0);
        check_eq("rst_dim",   32'(dim_video),    32'h0);
        check_eq("rst_addr",  32'(bus.ram_addr), 32'h2AA);
        check_eq("rst_we",    32'(bus.ram_we),   32'h1);
        bus.cpu_we = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        tick();

        // Basic grant via vblank edge, then release
        bus.hs_req = 1'b1;
        #1;
        check_eq("g_c0_pause", 32'(cpu_pause), 32'h0);
        for (int c = 1; c <= 24; c++) begin
            tick();
            if (c == 1)  check_eq("g_c1_pause", 32'(cpu_pause), 32'h1);
            if (c == 10) vblank = 1'b1;
            if (c == 11) vblank = 1'b0;
            if (c == 12) begin
                check_eq("g_c12_gnt",  32'(bus.hs_gnt),   32'h0);
                check_eq("g_c12_addr", 32'(bus.ram_addr), 32'h2AA);
            end
            if (c == 13) begin
                check_eq("g_c13_gnt",  32'(bus.hs_gnt),   32'h1);
                check_eq("g_c13_addr", 32'(bus.ram_addr), 32'h155);
                bus.cpu_we = 1'b1;
                #1;
                check_eq("g_cpu_we_blocked", 32'(bus.ram_we), 32'h0);
                bus.hs_we = 1'b1;
                #1;
                check_eq("g_hs_we",   32'(bus.ram_we),   32'h1);
                check_eq("g_hs_din",  32'(bus.ram_din),  32'hA5);
                check_eq("g_hs_dout", 32'(bus.hs_dout),  32'h5A);
                check_eq("g_cpu_dout",32'(bus.cpu_dout), 32'h5A);
                bus.hs_we = 1'b0;
            end
            if (c == 20) begin
                check_eq("g_c20_gnt", 32'(bus.hs_gnt), 32'h1);
                bus.hs_req = 1'b0;
            end
            if (c == 21) begin
                check_eq("r_c21_gnt",  32'(bus.hs_gnt),   32'h0);
                check_eq("r_c21_addr", 32'(bus.ram_addr), 32'h2AA);
                check_eq("r_c21_we",   32'(bus.ram_we),   32'h1);
                check_eq("r_c21_din",  32'(bus.ram_din),  32'h3C);
            end
            if (c == 23) check_eq("r_c23_pause", 32'(cpu_pause), 32'h1);
            if (c == 24) check_eq("r_c24_pause", 32'(cpu_pause), 32'h0);
        end
        bus.cpu_we = 1'b0;

        // Timeout grant with vblank held low: WAIT_VBL entry at c1, grant at c1+16+2
        bus.hs_req = 1'b1;
        for (int c = 1; c <= 19; c++) begin
            tick();
            if (c == 18) check_eq("t_c18_gnt", 32'(bus.hs_gnt), 32'h0);
            if (c == 19) check_eq("t_c19_gnt", 32'(bus.hs_gnt), 32'h1);
        end
        bus.hs_req = 1'b0;
        for (int c = 1; c <= 5; c++) tick();
        check_eq("t_idle_pause", 32'(cpu_pause), 32'h0);

        // Request withdrawn while waiting for vblank: no grant ever issued
        bus.hs_req = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 3) bus.hs_req = 1'b0;
            if (c == 4) check_eq("a_c4_gnt",   32'(bus.hs_gnt), 32'h0);
            if (c == 6) check_eq("a_c6_pause", 32'(cpu_pause),  32'h1);
            if (c == 7) check_eq("a_c7_pause", 32'(cpu_pause),  32'h0);
        end

        // Pause toggle held for three cycles, dim after 100 cycles, second pulse
        pause_btn = 1'b1;
        for (int c = 1; c <= 107; c++) begin
            tick();
            if (c == 1) begin
                check_eq("p_c1_pause", 32'(cpu_pause), 32'h1);
                check_eq("p_c1_dim",   32'(dim_video), 32'h0);
            end
            if (c == 3)   pause_btn = 1'b0;
            if (c == 4)   check_eq("p_hold_single", 32'(cpu_pause), 32'h1);
            if (c == 100) check_eq("p_c100_dim", 32'(dim_video), 32'h0);
            if (c == 101) check_eq("p_c101_dim", 32'(dim_video), 32'h1);
            if (c == 105) pause_btn = 1'b1;
            if (c == 106) begin
                pause_btn = 1'b0;
                check_eq("p_off_pause", 32'(cpu_pause), 32'h0);
            end
            if (c == 107) check_eq("p_off_dim", 32'(dim_video), 32'h0);
        end

        // OSD pause: immediate, never dims
        osd_pause = 1'b1;
        #1;
        check_eq("o_pause", 32'(cpu_pause), 32'h1);
        for (int c = 1; c <= 105; c++) tick();
        check_eq("o_nodim", 32'(dim_video), 32'h0);
        osd_pause = 1'b0;
        #1;
        check_eq("o_release", 32'(cpu_pause), 32'h0);

        // Overlap: user pause stays asserted across a whole hiscore grant
        pause_btn  = 1'b1;
        bus.hs_req = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            tick();
            if (c == 1)  pause_btn = 1'b0;
            if (c == 5)  vblank = 1'b1;
            if (c == 6)  vblank = 1'b0;
            if (c == 8)  check_eq("v_c8_gnt", 32'(bus.hs_gnt), 32'h1);
            if (c == 10) bus.hs_req = 1'b0;
            if (c == 11) check_eq("v_c11_gnt", 32'(bus.hs_gnt), 32'h0);
            check_eq("v_pause", 32'(cpu_pause), 32'h1);
        end

        // Asynchronous reset while in GRANT (user pause still on)
        bus.hs_req = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 2) vblank = 1'b1;
            if (c == 3) vblank = 1'b0;
        end
        check_eq("x_gnt_before", 32'(bus.hs_gnt), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("x_gnt",   32'(bus.hs_gnt),   32'h0);
        check_eq("x_addr",  32'(bus.ram_addr), 32'h2AA);
        check_eq("x_pause", 32'(cpu_pause),    32'h0);
        check_eq("x_dim",   32'(dim_video),    32'h0);
        bus.hs_req = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        tick();
        check_eq("x_after_gnt",   32'(bus.hs_gnt), 32'h0);
        check_eq("x_after_pause", 32'(cpu_pause),  32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
